// File: rtl/frac_baud_tick_generator.sv
// Fractional-N baud tick generator: oversample, mid-bit and bit-end strobes for UART TX/RX,
// with runtime divisor/oversampling reconfiguration applied only at bit boundaries.
module frac_baud_tick_generator #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 8,
    parameter int OS_W         = 5,
    parameter int OS_MAX       = 16,
    parameter int DEF_DIV_INT  = 325,
    parameter int DEF_DIV_FRAC = 133,
    parameter int DEF_OS       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              resync,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic [OS_W-1:0]   cfg_os_factor,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [OS_W-1:0]   os_idx,
    output logic              cfg_pending,
    output logic              cfg_err
);

    localparam logic [DIV_W-1:0]  DEF_DIV_INT_C  = DIV_W'(DEF_DIV_INT);
    localparam logic [FRAC_W-1:0] DEF_DIV_FRAC_C = FRAC_W'(DEF_DIV_FRAC);
    localparam logic [OS_W-1:0]   DEF_OS_C       = OS_W'(DEF_OS);
    localparam logic [OS_W-1:0]   OS_MAX_C       = OS_W'(OS_MAX);
    localparam logic [DIV_W-1:0]  DIV_ONE        = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_TWO        = DIV_W'(2);
    localparam logic [OS_W-1:0]   OS_ONE         = OS_W'(1);
    localparam logic [OS_W-1:0]   OS_TWO         = OS_W'(2);

    // Active configuration
    logic [DIV_W-1:0]  div_int_q,  div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [OS_W-1:0]   os_q,       os_d;

    // Pending configuration
    logic              pend_vld_q,  pend_vld_d;
    logic [DIV_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [OS_W-1:0]   pend_os_q,   pend_os_d;

    // Phase state
    logic [DIV_W-1:0]  cnt_q,    cnt_d;
    logic [FRAC_W-1:0] acc_q,    acc_d;
    logic [OS_W-1:0]   os_idx_q, os_idx_d;

    // Registered strobes
    logic os_tick_q,  os_tick_d;
    logic mid_tick_q, mid_tick_d;
    logic bit_tick_q, bit_tick_d;
    logic cfg_err_q,  cfg_err_d;

    logic              cfg_legal;
    logic              load_ok;
    logic              tick_ev;
    logic              wrap;
    logic              apply_pend;
    logic [FRAC_W:0]   frac_sum;
    logic              carry;
    logic [OS_W-1:0]   idx_inc;
    logic [DIV_W-1:0]  new_div_int;
    logic [FRAC_W-1:0] new_div_frac;
    logic [OS_W-1:0]   new_os;

    always_comb begin
        cfg_legal = (cfg_div_int >= DIV_TWO) &&
                    (cfg_os_factor >= OS_TWO) &&
                    (cfg_os_factor <= OS_MAX_C);
        load_ok   = cfg_load && cfg_legal;

        tick_ev   = enable && !resync && (cnt_q == '0);
        wrap      = (os_idx_q >= (os_q - OS_ONE));
        idx_inc   = os_idx_q + OS_ONE;
        frac_sum  = {1'b0, acc_q} + {1'b0, div_frac_q};
        carry     = frac_sum[FRAC_W];

        // Pending config takes over at any phase restart point: idle, resync or bit wrap
        apply_pend   = pend_vld_q && (!enable || resync || (tick_ev && wrap));
        new_div_int  = apply_pend ? pend_int_q  : div_int_q;
        new_div_frac = apply_pend ? pend_frac_q : div_frac_q;
        new_os       = apply_pend ? pend_os_q   : os_q;
    end

    always_comb begin
        div_int_d   = new_div_int;
        div_frac_d  = new_div_frac;
        os_d        = new_os;

        pend_vld_d  = pend_vld_q && !apply_pend;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_os_d   = pend_os_q;
        if (load_ok) begin
            pend_vld_d  = 1'b1;
            pend_int_d  = cfg_div_int;
            pend_frac_d = cfg_div_frac;
            pend_os_d   = cfg_os_factor;
        end

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        os_idx_d   = os_idx_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        cfg_err_d  = cfg_load && !cfg_legal;

        if (!enable || resync) begin
            cnt_d    = new_div_int - DIV_ONE;
            acc_d    = '0;
            os_idx_d = '0;
        end else if (tick_ev) begin
            // Fractional carry stretches the period that starts now by one clock
            acc_d      = frac_sum[FRAC_W-1:0];
            cnt_d      = new_div_int - DIV_ONE + {{(DIV_W-1){1'b0}}, carry};
            os_idx_d   = wrap ? '0 : idx_inc;
            os_tick_d  = 1'b1;
            bit_tick_d = wrap;
            mid_tick_d = !wrap && (idx_inc == (os_q >> 1));
        end else begin
            cnt_d = cnt_q - DIV_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_int_q  <= DEF_DIV_INT_C;
            div_frac_q <= DEF_DIV_FRAC_C;
            os_q       <= DEF_OS_C;
            pend_vld_q <= 1'b0;
            cnt_q      <= DEF_DIV_INT_C - DIV_ONE;
            acc_q      <= '0;
            os_idx_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            os_q       <= os_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_idx_q   <= os_idx_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    // Pending payload is only consumed while pend_vld_q is set, so it needs no reset
    always_ff @(posedge clk) begin
        pend_int_q  <= pend_int_d;
        pend_frac_q <= pend_frac_d;
        pend_os_q   <= pend_os_d;
    end

    assign os_tick     = os_tick_q;
    assign mid_tick    = mid_tick_q;
    assign bit_tick    = bit_tick_q;
    assign os_idx      = os_idx_q;
    assign cfg_pending = pend_vld_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_frac_baud_tick_generator.sv
// Directed bench for frac_baud_tick_generator: tick spacing, fractional carry, config
// deferral/rejection, resync and reset behaviour against hand-computed values.
module tb_frac_baud_tick_generator;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        resync;
    logic        cfg_load;
    logic [15:0] cfg_div_int;
    logic [7:0]  cfg_div_frac;
    logic [4:0]  cfg_os_factor;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic [4:0]  os_idx;
    logic        cfg_pending;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    frac_baud_tick_generator dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .resync        (resync),
        .cfg_load      (cfg_load),
        .cfg_div_int   (cfg_div_int),
        .cfg_div_frac  (cfg_div_frac),
        .cfg_os_factor (cfg_os_factor),
        .os_tick       (os_tick),
        .mid_tick      (mid_tick),
        .bit_tick      (bit_tick),
        .os_idx        (os_idx),
        .cfg_pending   (cfg_pending),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; strobes are cleared after each edge so they last exactly one cycle
    task automatic step();
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (os_tick !== 1'b1 && n < 600);
    endtask

    task automatic load_cfg(input int di, input int fr, input int os);
        cfg_div_int   = 16'(di);
        cfg_div_frac  = 8'(fr);
        cfg_os_factor = 5'(os);
        cfg_load      = 1'b1;
    endtask

    task automatic idle_load(input int di, input int fr, input int os);
        enable = 1'b0;
        step();
        load_cfg(di, fr, os);
        step();
        step();
    endtask

    initial begin
        int n;
        int cnt;
        int exp2[5];
        exp2 = '{4, 4, 5, 4, 5};

        rst = 1'b1; enable = 1'b0; resync = 1'b0; cfg_load = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0; cfg_os_factor = '0;
        step();
        step();
        chk("rst_os_tick", os_tick, 0);
        chk("rst_mid_tick", mid_tick, 0);
        chk("rst_bit_tick", bit_tick, 0);
        chk("rst_os_idx", os_idx, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;

        // Test 1: div 4, frac 0, os 4
        load_cfg(4, 0, 4);
        step();
        chk("t1_pending_set", cfg_pending, 1);
        step();
        chk("t1_pending_idle_apply", cfg_pending, 0);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_tick(n);
            chk($sformatf("t1_gap%0d", i), n, 4);
            chk($sformatf("t1_mid%0d", i), mid_tick, (i == 2) ? 1 : 0);
            chk($sformatf("t1_bit%0d", i), bit_tick, (i == 4) ? 1 : 0);
            chk($sformatf("t1_idx%0d", i), os_idx, i % 4);
        end
        step();
        chk("t1_tick_width", os_tick, 0);

        // Test 2: div 4, frac 128 -> periods 4,4,5,4,5 and 200 ticks per 900 clocks
        idle_load(4, 128, 16);
        chk("t2_idle_idx", os_idx, 0);
        chk("t2_idle_no_tick", os_tick, 0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            chk($sformatf("t2_gap%0d", i), n, exp2[i]);
        end
        cnt = 0;
        for (int i = 0; i < 900; i++) begin
            step();
            if (os_tick === 1'b1) cnt++;
        end
        chk("t2_count_199_201", (cnt >= 199 && cnt <= 201) ? 1 : 0, 1);

        // Test 3: load div 6 at os_idx 5, takes effect after the bit boundary
        idle_load(4, 0, 16);
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_tick(n);
            chk($sformatf("t3_gap%0d", i), n, 4);
        end
        chk("t3_idx5", os_idx, 5);
        load_cfg(6, 0, 16);
        for (int i = 6; i <= 16; i++) begin
            wait_tick(n);
            chk($sformatf("t3_gap%0d", i), n, 4);
            if (i < 16) begin
                chk($sformatf("t3_pending%0d", i), cfg_pending, 1);
            end else begin
                chk("t3_bit16", bit_tick, 1);
                chk("t3_pending_cleared", cfg_pending, 0);
            end
        end
        wait_tick(n);
        chk("t3_new_gap_a", n, 6);
        wait_tick(n);
        chk("t3_new_gap_b", n, 6);

        // Test 4: illegal loads rejected, spacing unchanged
        load_cfg(1, 0, 16);
        step();
        chk("t4a_err", cfg_err, 1);
        chk("t4a_pending", cfg_pending, 0);
        step();
        chk("t4a_err_width", cfg_err, 0);
        wait_tick(n);
        chk("t4a_gap_rest", n, 4);
        wait_tick(n);
        chk("t4a_gap", n, 6);
        load_cfg(6, 0, 17);
        step();
        chk("t4b_err", cfg_err, 1);
        chk("t4b_pending", cfg_pending, 0);
        step();
        chk("t4b_err_width", cfg_err, 0);
        wait_tick(n);
        chk("t4b_gap_rest", n, 4);
        wait_tick(n);
        chk("t4b_gap", n, 6);

        // Test 5: resync at os_idx 9
        idle_load(4, 0, 16);
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) wait_tick(n);
        chk("t5_idx9", os_idx, 9);
        resync = 1'b1;
        step();
        chk("t5_resync_idx", os_idx, 0);
        chk("t5_resync_no_tick", os_tick, 0);
        wait_tick(n);
        chk("t5_first_gap", n, 4);
        chk("t5_first_bit", bit_tick, 0);
        for (int i = 2; i <= 16; i++) begin
            wait_tick(n);
            chk($sformatf("t5_bit%0d", i), bit_tick, (i == 16) ? 1 : 0);
        end

        // Test 6: reset at os_idx 7 with a pending config
        load_cfg(10, 0, 8);
        for (int i = 1; i <= 7; i++) wait_tick(n);
        chk("t6_idx7", os_idx, 7);
        chk("t6_pending", cfg_pending, 1);
        rst = 1'b1;
        step();
        chk("t6_os_tick", os_tick, 0);
        chk("t6_mid_tick", mid_tick, 0);
        chk("t6_bit_tick", bit_tick, 0);
        chk("t6_os_idx", os_idx, 0);
        chk("t6_pending_lost", cfg_pending, 0);
        chk("t6_err", cfg_err, 0);
        rst = 1'b0;
        wait_tick(n);
        chk("t6_def_gap1", n, 325);
        wait_tick(n);
        chk("t6_def_gap2", n, 325);
        wait_tick(n);
        chk("t6_def_gap3", n, 326);
        for (int i = 4; i <= 16; i++) begin
            wait_tick(n);
            chk($sformatf("t6_mid%0d", i), mid_tick, (i == 8) ? 1 : 0);
            chk($sformatf("t6_bit%0d", i), bit_tick, (i == 16) ? 1 : 0);
        end

        // Odd oversampling: os 5 -> mid on 2nd tick, bit on 5th
        idle_load(2, 0, 5);
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_tick(n);
            chk($sformatf("t7_gap%0d", i), n, 2);
            chk($sformatf("t7_mid%0d", i), mid_tick, (i == 2) ? 1 : 0);
            chk($sformatf("t7_bit%0d", i), bit_tick, (i == 5) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
